lfsr_decrypt: RTL and testbench
===============================

LFSR_DECRYPT -- requirements
Module: lfsr_decrypt

Interface
REQ-001 SHALL have parameters: DW, 8, ROM data width; AW, 8, ROM address width; LFSR_W, 5, LFSR width.
REQ-002 SHALL have ports, one clock and asynchronous active-low reset:
 clk  in  1  sole clock, all state on rising edge
 rst  in  1  asynchronous active-low reset
 decRqst  in  1  start request, level
 validIn  in  1  encByte valid this cycle
 encByte  in  8  encrypted stream byte
 raddr  out  AW  ROM read address
 rdata  in  DW  ROM data, registered, 1-cycle latency
 plainByte  out  8  decrypted byte
 validOut  out  1  plainByte valid, 1-cycle pulse per byte
 done  out  1  decryption complete
 preambleErr  out  1  sticky preamble mismatch flag

Function
REQ-003 SHALL read these ROM words: addr 0 preamble length P; addr 1 taps[LFSR_W-1:0]; addr 2 seed[LFSR_W-1:0]; addr 3 message length M.
REQ-004 SHALL implement states IDLE, RD0, RD1, RD2, RD3, RD4, PRE, MSG, DONE.
REQ-005 IDLE: on decRqst=1, SHALL clear preambleErr and go to RD0.
REQ-006 RDk: SHALL drive raddr=k for k<=3, latch rdata issued in RD(k-1), and go to RD(k+1); RD4 latches M and loads LFSR with the seed.
REQ-007 From RD4: SHALL go to PRE if P!=0, else MSG if M!=0, else DONE.
REQ-008 SHALL advance the LFSR once per accepted byte, with next = {s[LFSR_W-2:0], ^(s & taps)}; a zero seed stays zero with no special case.
REQ-009 SHALL accept a byte only when validIn=1 in PRE or MSG; validIn SHALL be ignored in all other states.
REQ-010 PRE: for each accepted byte, SHALL set preambleErr if (encByte ^ {3'b000,lfsr}) != 8'h7E; SHALL NOT output preamble bytes; after the P-th byte SHALL go to MSG, or to DONE if M=0.
REQ-011 MSG: accepted byte at cycle t SHALL give plainByte = (encByte ^ {3'b000,lfsr}) & 8'h7F with validOut=1 at t+1 (registered); after the M-th byte SHALL go to DONE.
REQ-012 DONE: SHALL hold done=1 and go to IDLE when decRqst=0; done SHALL be 0 in all other states.
REQ-013 decRqst asserted outside IDLE SHALL be ignored, with no restart.
REQ-014 Byte counters SHALL be AW bits; P and M range 0..255; no wrap beyond the count.
REQ-015 preambleErr SHALL NOT stop decryption; it holds until the next IDLE->RD0 transition.
REQ-016 raddr SHALL be 0 in every state other than RD0..RD3.

Reset
REQ-017 rst=0 SHALL asynchronously force: state IDLE; raddr 0; plainByte 8'h00; validOut, done, preambleErr 0; LFSR, taps, P, M and counters 0.
REQ-018 Reset mid-operation SHALL abandon the transfer; after release the block SHALL wait for a new decRqst.

Structure
REQ-019 Package lab4_pkg SHALL hold the state enum, ROM address constants (0..3) and PREAMBLE_CHAR=8'h7E.
REQ-020 The LFSR SHALL be a sub-module lfsr (parameter LFSR_W; ports clk, rst, load, en, seed, taps, state).
REQ-021 Control FSM and datapath SHALL reside in lfsr_decrypt; total 120-400 RTL lines.

Verification
REQ-022 ROM {P=2, taps=0x14, seed=0x01, M=1}, stream 0x7F,0x7C,0xC5 -> one validOut with plainByte=0x41, preambleErr=0, then done=1.
REQ-023 Same ROM, stream 0x7F,0x7D,0xC5 -> preambleErr=1 after the 2nd byte, plainByte=0x41 still output, done=1.
REQ-024 P=0, M=0 -> done=1 exactly 5 cycles after decRqst, with no validOut.
REQ-025 Same ROM as REQ-022, with validIn gaps between bytes and validIn=1 during RD0..RD4 -> identical output; bytes sent during reads are ignored.
REQ-026 rst pulsed low in MSG -> all outputs 0 immediately; next decRqst restarts and re-reads addresses 0..3.

Source files
------------

// File: rtl/lab4_pkg.sv
// Shared definitions for the LFSR stream decryptor.
//   state_t        : control FSM states
//   ADDR_*         : fixed ROM word addresses of the configuration block
//   PREAMBLE_CHAR  : plaintext value every preamble byte must decrypt to
package lab4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        RD4,
        PRE,
        MSG,
        DONE
    } state_t;

    localparam int unsigned ADDR_PLEN = 0;  // preamble length P
    localparam int unsigned ADDR_TAPS = 1;  // LFSR feedback taps
    localparam int unsigned ADDR_SEED = 2;  // LFSR seed
    localparam int unsigned ADDR_MLEN = 3;  // message length M

    localparam logic [7:0] PREAMBLE_CHAR = 8'h7E;

endpackage

// File: rtl/lfsr.sv
// Fibonacci-style shift-left LFSR with run-time taps.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears the state
//   load  : load seed (has priority over en)
//   en    : advance one step
//   seed  : value loaded on load
//   taps  : feedback tap mask
//   state : current LFSR contents
module lfsr #(
    parameter int LFSR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LFSR_W-1:0] taps,
    output logic [LFSR_W-1:0] state
);

    // Feedback is the parity of the tapped bits; an all-zero state stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= {state[LFSR_W-2:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/lfsr_decrypt.sv
// Stream decryptor: reads P, taps, seed and M from a ROM, checks P preamble bytes
// and emits M decrypted message bytes (key = LFSR state, one step per byte).
//   clk, rst    : clock / asynchronous active-low reset
//   decRqst     : start request (level), ignored outside IDLE
//   validIn     : encByte valid this cycle
//   encByte     : encrypted byte
//   raddr/rdata : ROM port, rdata arrives one cycle after raddr
//   plainByte   : decrypted byte, qualified by validOut (one pulse per byte)
//   done        : high while the finished state is held
//   preambleErr : sticky preamble mismatch, cleared on the next start
module lfsr_decrypt
    import lab4_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int LFSR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          decRqst,
    input  logic          validIn,
    input  logic [7:0]    encByte,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [7:0]    plainByte,
    output logic          validOut,
    output logic          done,
    output logic          preambleErr
);

    state_t              state;
    logic [DW-1:0]       p_len;
    logic [DW-1:0]       m_len;
    logic [LFSR_W-1:0]   taps_q;
    logic [LFSR_W-1:0]   seed_q;
    logic [AW-1:0]       cnt;
    logic [LFSR_W-1:0]   lfsr_state;

    logic                accept;
    logic [7:0]          dec_byte;
    logic [AW-1:0]       cnt_inc;
    logic                last_pre;
    logic                last_msg;

    assign accept   = validIn && ((state == PRE) || (state == MSG));
    assign dec_byte = encByte ^ {{(8 - LFSR_W){1'b0}}, lfsr_state};
    assign cnt_inc  = cnt + AW'(1);
    assign last_pre = (cnt_inc == AW'(p_len));
    assign last_msg = (cnt_inc == AW'(m_len));

    // Seed captured in RD3 is loaded as the last read completes, so the first
    // streamed byte sees the seed as its key.
    lfsr #(
        .LFSR_W(LFSR_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (state == RD4),
        .en   (accept),
        .seed (seed_q),
        .taps (taps_q),
        .state(lfsr_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            raddr       <= '0;
            plainByte   <= 8'h00;
            validOut    <= 1'b0;
            done        <= 1'b0;
            preambleErr <= 1'b0;
            p_len       <= '0;
            m_len       <= '0;
            taps_q      <= '0;
            seed_q      <= '0;
            cnt         <= '0;
        end else begin
            validOut <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (decRqst) begin
                        preambleErr <= 1'b0;
                        raddr       <= AW'(ADDR_PLEN);
                        state       <= RD0;
                    end
                end
                // raddr is set one edge early so it equals k while in RDk.
                RD0: begin
                    raddr <= AW'(ADDR_TAPS);
                    state <= RD1;
                end
                RD1: begin
                    p_len <= rdata;
                    raddr <= AW'(ADDR_SEED);
                    state <= RD2;
                end
                RD2: begin
                    taps_q <= rdata[LFSR_W-1:0];
                    raddr  <= AW'(ADDR_MLEN);
                    state  <= RD3;
                end
                RD3: begin
                    seed_q <= rdata[LFSR_W-1:0];
                    raddr  <= '0;
                    state  <= RD4;
                end
                RD4: begin
                    m_len <= rdata;
                    cnt   <= '0;
                    if (p_len != '0) begin
                        state <= PRE;
                    end else if (rdata != '0) begin
                        state <= MSG;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                PRE: begin
                    if (validIn) begin
                        if (dec_byte != PREAMBLE_CHAR) begin
                            preambleErr <= 1'b1;
                        end
                        if (last_pre) begin
                            cnt <= '0;
                            if (m_len != '0) begin
                                state <= MSG;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                MSG: begin
                    if (validIn) begin
                        plainByte <= dec_byte & 8'h7F;
                        validOut  <= 1'b1;
                        if (last_msg) begin
                            cnt   <= '0;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                DONE: begin
                    if (!decRqst) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Self-checking bench for lfsr_decrypt: a ROM model, a transaction-level reference
// (key sequence from the LFSR rule, expected plaintext queue, sticky error flag)
// and a per-cycle compare process on validOut/plainByte.
module tb_lfsr_decrypt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       decRqst = 1'b0;
    logic       validIn = 1'b0;
    logic [7:0] encByte = 8'h00;
    logic [7:0] raddr;
    logic [7:0] rdata = 8'h00;
    logic [7:0] plainByte;
    logic       validOut;
    logic       done;
    logic       preambleErr;

    int n_tests = 0;
    int n_fail  = 0;
    int vo_count = 0;
    logic [7:0] last_plain = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] fixed_q[$];
    logic [7:0] rom[4];

    lfsr_decrypt #(
        .DW    (8),
        .AW    (8),
        .LFSR_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .decRqst    (decRqst),
        .validIn    (validIn),
        .encByte    (encByte),
        .raddr      (raddr),
        .rdata      (rdata),
        .plainByte  (plainByte),
        .validOut   (validOut),
        .done       (done),
        .preambleErr(preambleErr)
    );

    always #5 clk = ~clk;

    // Registered ROM, one cycle of latency.
    always @(posedge clk) rdata <= (raddr < 8'd4) ? rom[raddr[1:0]] : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] lfsr_step(input logic [4:0] s, input logic [4:0] t);
        logic fb = 1'b0;
        for (int i = 0; i < 5; i++) fb = fb ^ (s[i] & t[i]);
        return {s[3:0], fb};
    endfunction

    // Every validOut must match the oldest outstanding expected plaintext byte.
    always @(negedge clk) begin
        if (rst && validOut) begin
            vo_count++;
            last_plain = plainByte;
            if (exp_q.size() == 0) begin
                check("unexpected_validOut", {24'h0, plainByte}, 32'hFFFF_FFFF);
            end else begin
                check("plainByte", {24'h0, plainByte}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_txn(input int p, input int tp, input int sd, input int m,
                           input bit gaps, input bit corrupt, input int abort_at);
        logic [4:0] s;
        logic [7:0] b;
        logic [7:0] key;
        bit err = 1'b0;
        rom[0] = p[7:0];
        rom[1] = tp[7:0];
        rom[2] = sd[7:0];
        rom[3] = m[7:0];
        decRqst = 1'b1;
        validIn = 1'b0;
        @(posedge clk); #1;
        // Five configuration-read cycles; bytes offered here must be ignored.
        for (int k = 0; k < 5; k++) begin
            check("read_raddr", {24'h0, raddr}, (k < 4) ? k : 0);
            check("read_done", {31'h0, done}, 0);
            validIn = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            encByte = 8'($urandom);
            @(posedge clk); #1;
        end
        validIn = 1'b0;
        s = sd[4:0];
        if (p + m == 0) check("done_after_reads", {31'h0, done}, 1);
        for (int i = 0; i < p + m; i++) begin
            if (i == abort_at) begin
                @(negedge clk); #1;
                rst = 1'b0;
                #1;
                check("rst_validOut", {31'h0, validOut}, 0);
                check("rst_done", {31'h0, done}, 0);
                check("rst_err", {31'h0, preambleErr}, 0);
                check("rst_plain", {24'h0, plainByte}, 0);
                check("rst_raddr", {24'h0, raddr}, 0);
                exp_q.delete();
                validIn = 1'b0;
                decRqst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                check("post_rst_done", {31'h0, done}, 0);
                check("post_rst_raddr", {24'h0, raddr}, 0);
                return;
            end
            while (gaps && $urandom_range(0, 2) == 0) begin
                validIn = 1'b0;
                encByte = 8'($urandom);
                @(posedge clk); #1;
                check("gap_raddr", {24'h0, raddr}, 0);
                check("gap_done", {31'h0, done}, 0);
            end
            key = {3'b000, s};
            if (fixed_q.size() > i) begin
                b = fixed_q[i];
            end else if (i < p) begin
                b = 8'h7E ^ key;
                if (corrupt && $urandom_range(0, 3) == 0) b = b ^ 8'($urandom_range(1, 255));
            end else begin
                b = 8'($urandom);
            end
            if (i < p && ((b ^ key) != 8'h7E)) err = 1'b1;
            validIn = 1'b1;
            encByte = b;
            @(posedge clk); #1;
            validIn = 1'b0;
            if (i >= p) exp_q.push_back((b ^ key) & 8'h7F);
            s = lfsr_step(s, tp[4:0]);
            check("stream_err", {31'h0, preambleErr}, {31'h0, err});
            check("stream_done", {31'h0, done}, (i == p + m - 1) ? 1 : 0);
            check("stream_raddr", {24'h0, raddr}, 0);
        end
        @(negedge clk); #1;
        check("exp_q_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_hold", {31'h0, done}, 1);
        decRqst = 1'b0;
        @(posedge clk); #1;
        check("done_clear", {31'h0, done}, 0);
        check("err_sticky", {31'h0, preambleErr}, {31'h0, err});
        @(posedge clk); #1;
    endtask

    int vo0;

    initial begin
        rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h00;
        #1;
        check("reset_raddr", {24'h0, raddr}, 0);
        check("reset_plain", {24'h0, plainByte}, 0);
        check("reset_validOut", {31'h0, validOut}, 0);
        check("reset_done", {31'h0, done}, 0);
        check("reset_err", {31'h0, preambleErr}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Pin the reference LFSR step with hand-worked values.
        check("model_step1", {27'h0, lfsr_step(5'h01, 5'h14)}, 32'h02);
        check("model_step2", {27'h0, lfsr_step(5'h02, 5'h14)}, 32'h04);
        check("model_step3", {27'h0, lfsr_step(5'h04, 5'h14)}, 32'h09);
        check("model_zero", {27'h0, lfsr_step(5'h00, 5'h1F)}, 32'h00);

        // Good preamble, one message byte.
        fixed_q = '{8'h7F, 8'h7C, 8'hC5};
        vo0 = vo_count;
        run_txn(2, 8'h14, 8'h01, 1, 1'b0, 1'b0, -1);
        check("req22_vo_count", vo_count - vo0, 1);
        check("req22_plain", {24'h0, last_plain}, 32'h41);
        check("req22_err", {31'h0, preambleErr}, 0);

        // Bad second preamble byte: flag set, message still delivered.
        fixed_q = '{8'h7F, 8'h7D, 8'hC5};
        vo0 = vo_count;
        run_txn(2, 8'h14, 8'h01, 1, 1'b0, 1'b0, -1);
        check("req23_vo_count", vo_count - vo0, 1);
        check("req23_plain", {24'h0, last_plain}, 32'h41);
        check("req23_err", {31'h0, preambleErr}, 1);

        // Empty transfer.
        fixed_q.delete();
        vo0 = vo_count;
        run_txn(0, 8'h14, 8'h01, 0, 1'b0, 1'b0, -1);
        check("req24_vo_count", vo_count - vo0, 0);

        // Gaps and bytes offered during reads.
        fixed_q = '{8'h7F, 8'h7C, 8'hC5};
        vo0 = vo_count;
        run_txn(2, 8'h14, 8'h01, 1, 1'b1, 1'b0, -1);
        check("req25_vo_count", vo_count - vo0, 1);
        check("req25_plain", {24'h0, last_plain}, 32'h41);
        check("req25_err", {31'h0, preambleErr}, 0);
        fixed_q.delete();

        // Reset in MSG, then a fresh transfer re-reads the ROM.
        run_txn(2, 8'h12, 8'h05, 4, 1'b0, 1'b0, 3);
        run_txn(1, 8'h1B, 8'h0A, 3, 1'b1, 1'b1, -1);

        // Counter boundaries.
        run_txn(255, 8'h12, 8'h01, 2, 1'b0, 1'b1, -1);
        run_txn(1, 8'h09, 8'h1F, 255, 1'b0, 1'b0, -1);
        run_txn(0, 8'h1D, 8'h03, 5, 1'b1, 1'b0, -1);
        run_txn(3, 8'h14, 8'h07, 0, 1'b1, 1'b1, -1);

        // Random transfers, including zero seeds.
        for (int t = 0; t < 25; t++) begin
            run_txn($urandom_range(0, 6), $urandom_range(0, 31),
                    ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 31),
                    $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
